// File: rtl/zx_raster_gen.sv
// Raster and interrupt timing generator for the Spectrum video path.
// Produces pixel/line counters, blanking/sync, frame and line interrupts,
// VRAM fetch-slot strobes and the flash phase for 48K, 128K and Pentagon timing.
module zx_raster_gen #(
  parameter int unsigned INT_LEN_48  = 64,
  parameter int unsigned INT_LEN_128 = 72,
  parameter int unsigned FLASH_W     = 5
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_7mn,
  input  logic [1:0] profile,
  input  logic       line_int_ena,
  input  logic [8:0] line_int_line,
  input  logic       line_int_ack,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output logic       border,
  output logic       hblank,
  output logic       hsync,
  output logic       vsync,
  output logic       int_n,
  output logic       line_int,
  output logic       fetch_en,
  output logic [1:0] fetch_phase,
  output logic       shift_load,
  output logic       frame_start,
  output logic       flash,
  output logic [1:0] active_profile
);

  localparam logic [1:0] Prof48       = 2'd0;
  localparam logic [1:0] Prof128      = 2'd1;
  localparam logic [1:0] ProfPentagon = 2'd2;

  // Registered state
  logic [8:0]         hc_q, hc_d;
  logic [8:0]         vc_q, vc_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [6:0]         int_cnt_q, int_cnt_d;
  logic [1:0]         active_profile_q, active_profile_d;
  logic               border_q, border_d;
  logic               hblank_q, hblank_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               int_n_q, int_n_d;
  logic               line_int_q, line_int_d;
  logic               fetch_en_q, fetch_en_d;
  logic [1:0]         fetch_phase_q, fetch_phase_d;
  logic               shift_load_q, shift_load_d;
  logic               frame_start_q, frame_start_d;
  // Border status captured at the start of the most recent fetch slot
  logic               slot_border_q, slot_border_d;

  // Profile constants
  logic [8:0] h_max, v_max;
  logic [8:0] hb_set, hb_clr, hs_set, hs_clr;
  logic [8:0] vs_set, vs_clr;
  logic [8:0] int_line, int_col;
  logic [6:0] int_len;

  // Decoded next position
  logic       hc_wrap, v_wrap;
  logic [8:0] hc_nxt, vc_nxt;
  logic       border_nxt;
  logic       load_pos;

  // Timing constants of the profile currently in force; reserved code falls back to 48K.
  always_comb begin
    h_max    = 9'd447;
    v_max    = 9'd311;
    hb_set   = 9'd312;
    hb_clr   = 9'd416;
    hs_set   = 9'd336;
    hs_clr   = 9'd368;
    vs_set   = 9'd240;
    vs_clr   = 9'd244;
    int_line = 9'd248;
    int_col  = 9'd4;
    int_len  = 7'(INT_LEN_48);
    case (active_profile_q)
      Prof128: begin
        h_max   = 9'd455;
        v_max   = 9'd310;
        hb_clr  = 9'd424;
        hs_set  = 9'd340;
        hs_clr  = 9'd372;
        int_col = 9'd8;
        int_len = 7'(INT_LEN_128);
      end
      ProfPentagon: begin
        v_max    = 9'd319;
        hb_clr   = 9'd420;
        hs_set   = 9'd338;
        hs_clr   = 9'd370;
        vs_set   = 9'd248;
        vs_clr   = 9'd256;
        int_line = 9'd239;
        int_col  = 9'd326;
      end
      default: ;
    endcase
  end

  // Next raster position and the position-derived decodes shared by the outputs.
  always_comb begin
    hc_wrap    = (hc_q == h_max);
    v_wrap     = hc_wrap && (vc_q == v_max);
    hc_nxt     = hc_wrap ? 9'd0 : hc_q + 9'd1;
    vc_nxt     = v_wrap ? 9'd0 : (hc_wrap ? vc_q + 9'd1 : vc_q);
    border_nxt = vc_nxt[8] | (vc_nxt[7] & vc_nxt[6]) | hc_nxt[8];
    load_pos   = (hc_nxt[3:0] == 4'd4) || (hc_nxt[3:0] == 4'd12);
  end

  // Counters, profile latch and raster outputs; everything holds without ce_7mn.
  always_comb begin
    hc_d             = hc_q;
    vc_d             = vc_q;
    flash_cnt_d      = flash_cnt_q;
    active_profile_d = active_profile_q;
    frame_start_d    = frame_start_q;
    border_d         = border_q;
    hblank_d         = hblank_q;
    hsync_d          = hsync_q;
    vsync_d          = vsync_q;
    fetch_en_d       = fetch_en_q;
    fetch_phase_d    = fetch_phase_q;
    shift_load_d     = shift_load_q;
    slot_border_d    = slot_border_q;
    if (ce_7mn) begin
      hc_d          = hc_nxt;
      vc_d          = vc_nxt;
      frame_start_d = v_wrap;
      if (v_wrap) begin
        flash_cnt_d      = flash_cnt_q + FLASH_W'(1);
        active_profile_d = (profile == 2'd3) ? Prof48 : profile;
      end
      border_d      = border_nxt;
      fetch_en_d    = !border_nxt && hc_nxt[3];
      fetch_phase_d = hc_nxt[1:0];
      if (hc_nxt[3:0] == 4'd8) slot_border_d = border_nxt;
      // A load only makes sense if the slot that fed it fetched real pixels.
      shift_load_d  = load_pos && !slot_border_q;
      if (hc_nxt == hb_set) hblank_d = 1'b1;
      else if (hc_nxt == hb_clr) hblank_d = 1'b0;
      if (hc_nxt == hs_set) hsync_d = 1'b1;
      else if (hc_nxt == hs_clr) hsync_d = 1'b0;
      if (vc_nxt == vs_set) vsync_d = 1'b1;
      else if (vc_nxt == vs_clr) vsync_d = 1'b0;
    end
  end

  // Frame interrupt: low from the INT position for exactly int_len ticks.
  always_comb begin
    int_n_d   = int_n_q;
    int_cnt_d = int_cnt_q;
    if (ce_7mn) begin
      if ((vc_nxt == int_line) && (hc_nxt == int_col)) begin
        int_n_d   = 1'b0;
        int_cnt_d = int_len;
      end else if (int_cnt_q != 7'd0) begin
        int_cnt_d = int_cnt_q - 7'd1;
        if (int_cnt_q == 7'd1) int_n_d = 1'b1;
      end
    end
  end

  // Sticky line interrupt; ack works on any clk_sys cycle, a coincident set wins.
  always_comb begin
    line_int_d = line_int_q;
    if (line_int_ack) line_int_d = 1'b0;
    if (ce_7mn && line_int_ena && (vc_nxt == line_int_line) && (hc_nxt == 9'd0)) begin
      line_int_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hc_q             <= 9'd0;
      vc_q             <= 9'd0;
      flash_cnt_q      <= '0;
      int_cnt_q        <= 7'd0;
      active_profile_q <= Prof48;
      border_q         <= 1'b0;
      hblank_q         <= 1'b0;
      hsync_q          <= 1'b0;
      vsync_q          <= 1'b0;
      int_n_q          <= 1'b1;
      line_int_q       <= 1'b0;
      fetch_en_q       <= 1'b0;
      fetch_phase_q    <= 2'd0;
      shift_load_q     <= 1'b0;
      frame_start_q    <= 1'b0;
      slot_border_q    <= 1'b1;
    end else begin
      hc_q             <= hc_d;
      vc_q             <= vc_d;
      flash_cnt_q      <= flash_cnt_d;
      int_cnt_q        <= int_cnt_d;
      active_profile_q <= active_profile_d;
      border_q         <= border_d;
      hblank_q         <= hblank_d;
      hsync_q          <= hsync_d;
      vsync_q          <= vsync_d;
      int_n_q          <= int_n_d;
      line_int_q       <= line_int_d;
      fetch_en_q       <= fetch_en_d;
      fetch_phase_q    <= fetch_phase_d;
      shift_load_q     <= shift_load_d;
      frame_start_q    <= frame_start_d;
      slot_border_q    <= slot_border_d;
    end
  end

  assign hc             = hc_q;
  assign vc             = vc_q;
  assign border         = border_q;
  assign hblank         = hblank_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign int_n          = int_n_q;
  assign line_int       = line_int_q;
  assign fetch_en       = fetch_en_q;
  assign fetch_phase    = fetch_phase_q;
  assign shift_load     = shift_load_q;
  assign frame_start    = frame_start_q;
  assign flash          = flash_cnt_q[FLASH_W-1];
  assign active_profile = active_profile_q;

endmodule

// File: doc/zx_raster_gen.md
# zx_raster_gen

Parametrised raster and interrupt timing generator for the Spectrum video subsystem. It produces the pixel/line counters, border, blanking, sync, frame interrupt, VRAM fetch-slot strobes and flash counter for 48K, 128K and Pentagon timings. It adds a runtime-selectable profile, applied only at frame boundaries, and a programmable line interrupt with acknowledge. Pixel-fetch, palette and contention logic consume its outputs.

## Interface
- `INT_LEN_48`, default 64: frame INT width in 7 MHz ticks for 48K and Pentagon profiles.
- `INT_LEN_128`, default 72: frame INT width in 7 MHz ticks for the 128K profile.
- `FLASH_W`, default 5: flash counter width; `flash` is the counter MSB.
- `clk_sys` in 1: master clock.
- `reset` in 1: synchronous, active-high; clock clk_sys.
- `ce_7mn` in 1: pixel-clock enable. All counter and output state advances only on this enable.
- `profile` in 2: requested timing. 0=48K, 1=128K, 2=Pentagon, 3=reserved (treated as 48K).
- `line_int_ena` in 1: line-interrupt enable.
- `line_int_line` in 9: line number for the line interrupt.
- `line_int_ack` in 1: single-clk_sys pulse that clears `line_int`.
- `hc` out 9: current pixel column.
- `vc` out 9: current line.
- `border` out 1: outside the 256×192 active area.
- `hblank`, `hsync`, `vsync` out 1 each: video timing outputs.
- `int_n` out 1: frame interrupt, active-low.
- `line_int` out 1: sticky line-interrupt flag.
- `fetch_en` out 1: VRAM fetch slot active.
- `fetch_phase` out 2: 0=bitmap address, 1=bitmap data, 2=attribute address, 3=attribute data.
- `shift_load` out 1: shift-register load strobe.
- `frame_start` out 1: one-tick pulse at frame wrap.
- `flash` out 1: flash phase.
- `active_profile` out 2: profile currently in force.

## Operation
- Per-profile constants (Hmax/Vmax; HBlank set..clr; HSync set..clr; VSync set..clr; INT line/col; INT length):
  - 48K: 447/311; 312..416; 336..368; 240..244; 248/4; INT_LEN_48.
  - 128K: 455/310; 312..424; 340..372; 240..244; 248/8; INT_LEN_128.
  - Pentagon: 447/319; 312..420; 338..370; 248..256; 239/326; INT_LEN_48.
- Counter update rules:
  - hc_next = (hc==Hmax) ? 0 : hc+1.
  - vc_next increments when hc wraps, and wraps to 0 after Vmax.
  - flash counter increments on each vertical wrap and wraps modulo 2^FLASH_W.
- Profile latching: `profile` is sampled into `active_profile` only on the tick where hc_next==0 and vc_next==0. That tick also pulses `frame_start` high. A mid-frame profile change has no effect until the next wrap.
- Output decoding: all outputs are decoded from hc_next/vc_next and registered on ce_7mn, so each output aligns with the registered hc/vc.
  - `border` = vc_next[8] | (vc_next[7]&vc_next[6]) | hc_next[8].
  - Set/clear pairs apply at the listed hc_next/vc_next values; each output holds its value between them.
- Frame INT:
  - At (INT line, INT col), `int_n` goes 0 and an internal 7-bit down-counter loads the profile's INT length.
  - The counter decrements on each ce_7mn tick. `int_n` returns to 1 on the tick the counter reaches 0, giving exactly INT_LEN ticks low.
- Line INT:
  - Sets when line_int_ena=1, vc_next==line_int_line and hc_next==0.
  - Clears on `line_int_ack`, which is evaluated every clk_sys cycle independent of ce_7mn.
  - If set and ack coincide, set wins.
  - A line number above Vmax never fires.
- Fetch slots:
  - `fetch_en` = !border_next & hc_next[3].
  - `fetch_phase` = hc_next[1:0].
  - `shift_load` = (hc_next[3:0]==4 | hc_next[3:0]==12); it is suppressed when the previous slot was border.

## Timing
- Reset values:
  - hc=0, vc=0, flash counter=0, INT counter=0, active_profile=0.
  - border=0, hblank=0, hsync=0, vsync=0, int_n=1, line_int=0, fetch_en=0, shift_load=0, frame_start=0.
  - `active_profile` loads `profile` on the first frame wrap after reset.
- Reset mid-INT: `int_n` returns to 1 on the next clk_sys edge, and the counter clears.
- Latency: each output is valid in the same ce_7mn tick as its matching hc/vc. Between ce ticks every register holds its value.
- Frame length in ticks:
  - 48K: 448×312 = 139776.
  - 128K: 456×311 = 141816.
  - Pentagon: 448×320 = 143360.
- Without ce_7mn, only `line_int` (via ack) and reset may change state.

## Test plan
- Profile 48K from reset: count ticks between `frame_start` pulses = 139776. `int_n` low exactly 64 ticks starting at vc=248, hc=4.
- Profile 128K: period 141816. `int_n` low 72 ticks from vc=248, hc=8. hsync high from hc=340 up to, not including, 372.
- Switch profile 0→2 at vc=100: the current frame still ends at vc=311. The next frame has 320 lines, and INT occurs at vc=239, hc=326.
- line_int_ena=1, line_int_line=100: `line_int` sets at vc=100, hc=0. An ack on the same clk as the next set leaves it 1. A lone ack clears it. line_int_line=400 never fires.
- Active area: at vc=0, hc=8..15 expect fetch_phase 0,1,2,3,0,1,2,3 with fetch_en=1, and shift_load at hc=12. At vc=192, fetch_en=0 and border=1.
- Assert reset while int_n=0: int_n=1 on the next clk. hc/vc=0. flash counter=0 after 2^FLASH_W frames toggles `flash` at 16-frame intervals (FLASH_W=5).
